spi_transaction_fsm: RTL and testbench

- Moore FSM that sequences one SPI slave transaction through the shift register, address latch, MISO buffer and data memory.
- Frame: WIDTH bits are shifted in MSB first. The top WIDTH-1 bits are the address; the LSB is R/W (1 = read).
- After the frame, either WIDTH bits of memory data are shifted out, or WIDTH bits are shifted in and written to memory.
- Sits between the input conditioners (synchronised chip select and sclk edge pulses) and the shift register / data memory datapath.

---
 rtl/spi_transaction_fsm.sv | 148 ++++++++++++++
 tb/tb_spi_transaction_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// spi_transaction_fsm
//
// Moore controller for one SPI slave transaction. A frame of WIDTH bits is
// shifted in MSB first: the upper WIDTH-1 bits are the address and the LSB is
// the R/W flag (1 = read). The frame is followed either by WIDTH bits of memory
// data shifted out on MISO, or by WIDTH bits shifted in and written to memory.
//
// Every output is decoded from the state register or comes straight from a
// flop. There is no combinational path from an input to an output.
//
// Ports
//   clk                 system clock. All state changes happen on its rising edge.
//   resetN              asynchronous active-low reset.
//   chipSelect          conditioned SPI chip select, active low.
//   sclkPosEdge         one-clk pulse on a conditioned SCLK rising edge.
//   sclkNegEdge         one-clk pulse on a conditioned SCLK falling edge.
//   rwBit               shift register parallelDataOut[0] (R/W flag).
//   addrLatchEnable     loads the address latch (GOT_ADDR).
//   shiftRegWriteEnable parallel-loads memory read data into the shift register (READ_LOAD).
//   misoBufferEnable    drives the MISO tri-state (READ_SHIFT).
//   dataMemWriteEnable  data memory write strobe (WRITE_MEM).
//   bitCount            current frame bit count, for debug.
//   fsmState            state encoding, for debug.
// -----------------------------------------------------------------------------
module spi_transaction_fsm #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       chipSelect,
  input  logic       sclkPosEdge,
  input  logic       sclkNegEdge,
  input  logic       rwBit,
  output logic       addrLatchEnable,
  output logic       shiftRegWriteEnable,
  output logic       misoBufferEnable,
  output logic       dataMemWriteEnable,
  output logic [3:0] bitCount,
  output logic [2:0] fsmState
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

  state_t     state_q, state_d;
  logic [3:0] bit_count_q, bit_count_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      bit_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;

    unique case (state_q)
      IDLE: begin
        bit_count_d = 4'd0;
        if (!chipSelect) state_d = GET_ADDR;
      end

      GET_ADDR: begin
        if (sclkPosEdge) begin
          if (bit_count_q == LAST_BIT) begin
            state_d     = GOT_ADDR;
            bit_count_d = 4'd0;
          end else begin
            bit_count_d = bit_count_q + 4'd1;
          end
        end
      end

      GOT_ADDR: state_d = rwBit ? READ_LOAD : WRITE_SHIFT;

      // Memory read is combinational from the latched address, so the data is
      // already valid while the shift register loads it here.
      READ_LOAD: state_d = READ_SHIFT;

      // The master samples MISO on the rising edge, so the slave advances the
      // read bit count on falling edges.
      READ_SHIFT: begin
        if (sclkNegEdge) begin
          if (bit_count_q == LAST_BIT) begin
            state_d     = DONE;
            bit_count_d = 4'd0;
          end else begin
            bit_count_d = bit_count_q + 4'd1;
          end
        end
      end

      WRITE_SHIFT: begin
        if (sclkPosEdge) begin
          if (bit_count_q == LAST_BIT) begin
            state_d     = WRITE_MEM;
            bit_count_d = 4'd0;
          end else begin
            bit_count_d = bit_count_q + 4'd1;
          end
        end
      end

      // The write strobe always completes its single cycle, even when CS has
      // already gone high.
      WRITE_MEM: state_d = chipSelect ? IDLE : DONE;

      // A finished transaction stays here until CS is released.
      DONE: state_d = DONE;

      default: begin
        state_d     = IDLE;
        bit_count_d = 4'd0;
      end
    endcase

    // A CS release aborts the transaction and takes priority over every other
    // transition. WRITE_MEM is excluded so that a started write finishes.
    if (chipSelect && (state_q != IDLE) && (state_q != WRITE_MEM)) begin
      state_d     = IDLE;
      bit_count_d = 4'd0;
    end
  end

  assign addrLatchEnable     = (state_q == GOT_ADDR);
  assign shiftRegWriteEnable = (state_q == READ_LOAD);
  assign misoBufferEnable    = (state_q == READ_SHIFT);
  assign dataMemWriteEnable  = (state_q == WRITE_MEM);
  assign bitCount            = bit_count_q;
  assign fsmState            = state_q;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_transaction_fsm
//
// Directed bench for spi_transaction_fsm with WIDTH = 8. Inputs change 1 time
// unit after a rising clock edge, and outputs are sampled at that same point,
// after the state registers have updated.
// -----------------------------------------------------------------------------
module tb_spi_transaction_fsm;

  logic       clk;
  logic       resetN;
  logic       chipSelect;
  logic       sclkPosEdge;
  logic       sclkNegEdge;
  logic       rwBit;
  logic       addrLatchEnable;
  logic       shiftRegWriteEnable;
  logic       misoBufferEnable;
  logic       dataMemWriteEnable;
  logic [3:0] bitCount;
  logic [2:0] fsmState;

  int checks = 0;
  int errors = 0;
  logic wr_seen;

  spi_transaction_fsm #(.WIDTH(8)) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .chipSelect          (chipSelect),
    .sclkPosEdge         (sclkPosEdge),
    .sclkNegEdge         (sclkNegEdge),
    .rwBit               (rwBit),
    .addrLatchEnable     (addrLatchEnable),
    .shiftRegWriteEnable (shiftRegWriteEnable),
    .misoBufferEnable    (misoBufferEnable),
    .dataMemWriteEnable  (dataMemWriteEnable),
    .bitCount            (bitCount),
    .fsmState            (fsmState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {ale, srwe, miso, dmwe}.
  function automatic logic [3:0] enables();
    return {addrLatchEnable, shiftRegWriteEnable, misoBufferEnable, dataMemWriteEnable};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (dataMemWriteEnable !== 1'b0) wr_seen = 1'b1;
  endtask

  task automatic pos_pulse();
    sclkPosEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
  endtask

  task automatic neg_pulse();
    sclkNegEdge = 1'b1;
    tick();
    sclkNegEdge = 1'b0;
  endtask

  // Starts a transaction from IDLE and shifts in an 8-bit frame. The R/W bit is
  // presented on the 8th pulse. Ends in GOT_ADDR.
  task automatic send_frame(input logic rw);
    chipSelect = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rwBit = (i == 7) ? rw : ~rw;
      pos_pulse();
    end
  endtask

  initial begin
    resetN      = 1'b0;
    chipSelect  = 1'b0;
    sclkPosEdge = 1'b1;
    sclkNegEdge = 1'b1;
    rwBit       = 1'b0;
    wr_seen     = 1'b0;

    // Reset held while CS is low and SCLK pulses keep arriving.
    repeat (3) tick();
    check("rst_state", fsmState, 0);
    check("rst_count", bitCount, 0);
    check("rst_enables", enables(), 4'b0000);
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    chipSelect  = 1'b1;
    resetN      = 1'b1;
    tick();
    check("idle_after_release", fsmState, 0);

    // Write transaction.
    chipSelect = 1'b0;
    tick();
    check("wr_get_addr", fsmState, 1);
    check("wr_get_addr_count0", bitCount, 0);
    sclkNegEdge = 1'b1;             // falling edges are ignored in GET_ADDR
    repeat (2) tick();
    sclkNegEdge = 1'b0;
    check("get_addr_neg_ignored", bitCount, 0);
    for (int i = 0; i < 7; i++) pos_pulse();
    check("wr_addr_count7", bitCount, 7);
    check("wr_addr_state1", fsmState, 1);
    rwBit = 1'b0;
    pos_pulse();
    check("wr_got_addr", fsmState, 2);
    check("wr_ale", enables(), 4'b1000);
    check("wr_count_cleared", bitCount, 0);
    tick();
    check("wr_write_shift", fsmState, 5);
    check("wr_ale_one_clk", enables(), 4'b0000);
    for (int i = 0; i < 7; i++) pos_pulse();
    check("wr_data_count7", bitCount, 7);
    check("wr_no_early_write", enables(), 4'b0000);
    pos_pulse();
    check("wr_mem_state", fsmState, 6);
    check("wr_mem_strobe", enables(), 4'b0001);
    tick();
    check("wr_done", fsmState, 7);
    check("wr_strobe_one_clk", enables(), 4'b0000);

    // DONE stays put while CS is low and ignores SCLK.
    for (int i = 0; i < 8; i++) pos_pulse();
    check("done_sticky_state", fsmState, 7);
    check("done_sticky_count", bitCount, 0);
    check("done_sticky_enables", enables(), 4'b0000);
    chipSelect = 1'b1;
    tick();
    check("done_to_idle", fsmState, 0);

    // Read transaction.
    send_frame(1'b1);
    check("rd_got_addr", enables(), 4'b1000);
    tick();
    check("rd_read_load", fsmState, 3);
    check("rd_srwe", enables(), 4'b0100);
    tick();
    check("rd_read_shift", fsmState, 4);
    check("rd_miso", enables(), 4'b0010);
    for (int i = 0; i < 3; i++) pos_pulse();
    check("rd_pos_ignored", bitCount, 0);
    // A simultaneous rising/falling pulse counts exactly once in READ_SHIFT.
    sclkPosEdge = 1'b1;
    neg_pulse();
    sclkPosEdge = 1'b0;
    check("rd_both_edges_once", bitCount, 1);
    for (int i = 0; i < 6; i++) neg_pulse();
    check("rd_count7", bitCount, 7);
    check("rd_miso_still_on", misoBufferEnable, 1'b1);
    neg_pulse();
    check("rd_done", fsmState, 7);
    check("rd_miso_off", enables(), 4'b0000);
    chipSelect = 1'b1;
    tick();
    check("rd_idle", fsmState, 0);

    // Abort during WRITE_SHIFT.
    send_frame(1'b0);
    tick();
    check("ab_write_shift", fsmState, 5);
    wr_seen = 1'b0;
    for (int i = 0; i < 5; i++) pos_pulse();
    check("ab_count5", bitCount, 5);
    chipSelect = 1'b1;
    tick();
    check("ab_idle", fsmState, 0);
    check("ab_count0", bitCount, 0);
    repeat (2) tick();
    check("ab_no_write", wr_seen, 1'b0);

    // Asynchronous reset in the middle of READ_SHIFT.
    send_frame(1'b1);
    repeat (2) tick();
    neg_pulse();
    check("ar_in_read_shift", fsmState, 4);
    #2;
    resetN = 1'b0;
    #1;                              // no clock edge between here and the reset
    check("ar_async_state", fsmState, 0);
    check("ar_async_miso", misoBufferEnable, 1'b0);
    check("ar_async_count", bitCount, 0);
    chipSelect = 1'b1;
    resetN     = 1'b1;
    tick();

    // A fresh transaction after reset starts counting from zero.
    chipSelect = 1'b0;
    tick();
    check("new_get_addr", fsmState, 1);
    check("new_count0", bitCount, 0);
    pos_pulse();
    check("new_count1", bitCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
